// File: rtl/q2a03_dma_arbiter_if.sv
// q2a03_dma_arbiter_if
// Signal bundle between the Q2A03 DMA arbiter, the CPU core, the system bus
// and the DMC sample fetcher.
//   master : arbiter view (drives cpu_ready, bus_*, dma_active, dmc_ack/data)
//   slave  : environment view (core, bus memory, DMC unit)
// Signal groups:
//   cpu_addr/cpu_wr_data/cpu_rdwr/cpu_ready  core side
//   bus_addr/bus_wr_data/bus_rdwr/bus_rd_data system bus side
//   dma_active                                DMA/arbitration busy flag
//   dmc_req/dmc_addr/dmc_ack/dmc_data         DMC single-byte fetch
interface q2a03_dma_arbiter_if;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wr_data;
    logic        cpu_rdwr;
    logic        cpu_ready;
    logic [15:0] bus_addr;
    logic [7:0]  bus_wr_data;
    logic        bus_rdwr;
    logic [7:0]  bus_rd_data;
    logic        dma_active;
    logic        dmc_req;
    logic [15:0] dmc_addr;
    logic        dmc_ack;
    logic [7:0]  dmc_data;

    modport master (
        input  cpu_addr, cpu_wr_data, cpu_rdwr, bus_rd_data, dmc_req, dmc_addr,
        output cpu_ready, bus_addr, bus_wr_data, bus_rdwr, dma_active, dmc_ack, dmc_data
    );

    modport slave (
        output cpu_addr, cpu_wr_data, cpu_rdwr, bus_rd_data, dmc_req, dmc_addr,
        input  cpu_ready, bus_addr, bus_wr_data, bus_rdwr, dma_active, dmc_ack, dmc_data
    );
endinterface

// File: rtl/q2a03_dma_arbiter.sv
// q2a03_dma_arbiter
// Bus arbiter and OAM DMA sequencer between the Q2A03 core and the system
// bus. A core write to OAM_REG stalls the core via cpu_ready and copies the
// 256-byte page {page, 00..FF} to OAM_DATA as alternating get/put cycles.
// Optional DMC single-byte fetches are enabled by defining Q2A03_DMC_DMA_EN;
// without it dmc_req/dmc_addr are ignored and dmc_ack/dmc_data stay 0.
// Ports:
//   G_clock  system clock
//   G_reset  synchronous active-low reset
//   G_cycle  one-clock strobe at the end of each CPU cycle
//   bus      q2a03_dma_arbiter_if.master (core, system bus, DMC signals)
//
// state   | meaning
// IDLE    | bus mirrors core, core runs
// HALT    | stall requested, waiting for the core to reach a read cycle
// ALIGN   | filler read cycle so the next get lands on phase 0
// GET     | read {page, idx} into buffer
// PUT     | write buffer to OAM_DATA, advance idx
// DMC_GET | read one DMC sample byte from dmc_addr
module q2a03_dma_arbiter #(
    parameter logic [15:0] OAM_REG  = 16'h4014,
    parameter logic [15:0] OAM_DATA = 16'h2004
) (
    input  logic G_clock,
    input  logic G_reset,
    input  logic G_cycle,
    q2a03_dma_arbiter_if.master bus
);
    typedef enum logic [2:0] {IDLE, HALT, ALIGN, GET, PUT, DMC_GET} state_t;

    state_t      state, state_nx, slot_nx;
    logic        phase;
    logic [7:0]  page, idx, buffer;
    logic        oam_run;
    logic        cpu_ready_q, dma_active_q;
    logic        dmc_pend, oam_trig;
    logic [15:0] addr_c;
    logic [7:0]  wr_data_c;
    logic        rdwr_c;

    assign oam_trig = !bus.cpu_rdwr && (bus.cpu_addr == OAM_REG);

    // Destination of a get slot: DMC wins, otherwise the OAM get, otherwise
    // a DMC-only halt whose request went away simply ends.
    always_comb begin
        slot_nx = IDLE;
        if (dmc_pend)
            slot_nx = DMC_GET;
        else if (oam_run)
            slot_nx = GET;
    end

    always_comb begin
        state_nx  = state;
        addr_c    = bus.cpu_addr;
        wr_data_c = bus.cpu_wr_data;
        rdwr_c    = bus.cpu_rdwr;
        case (state)
            IDLE:    if (oam_trig || dmc_pend) state_nx = HALT;
            // phase is the current cycle; a get must land where the next phase is 0
            HALT:    if (bus.cpu_rdwr) state_nx = phase ? slot_nx : ALIGN;
            ALIGN: begin
                rdwr_c   = 1'b1;
                state_nx = slot_nx;
            end
            GET: begin
                addr_c   = {page, idx};
                rdwr_c   = 1'b1;
                state_nx = PUT;
            end
            PUT: begin
                addr_c    = OAM_DATA;
                wr_data_c = buffer;
                rdwr_c    = 1'b0;
                state_nx  = (idx == 8'hFF) ? IDLE : slot_nx;
            end
            DMC_GET: begin
                addr_c   = bus.dmc_addr;
                rdwr_c   = 1'b1;
                // the interrupted OAM get retries on the next phase-0 slot
                state_nx = oam_run ? ALIGN : IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge G_clock) begin
        if (!G_reset) begin
            state        <= IDLE;
            phase        <= 1'b0;
            page         <= 8'h00;
            idx          <= 8'h00;
            buffer       <= 8'h00;
            oam_run      <= 1'b0;
            cpu_ready_q  <= 1'b1;
            dma_active_q <= 1'b0;
        end else if (G_cycle) begin
            state        <= state_nx;
            phase        <= ~phase;
            cpu_ready_q  <= (state_nx == IDLE);
            dma_active_q <= (state_nx != IDLE);
            case (state)
                // HALT also catches a trigger issued while halted for a DMC fetch
                IDLE, HALT: if (oam_trig && !oam_run) begin
                    page    <= bus.cpu_wr_data;
                    idx     <= 8'h00;
                    oam_run <= 1'b1;
                end
                GET: buffer <= bus.bus_rd_data;
                PUT: begin
                    idx <= idx + 8'd1;
                    if (idx == 8'hFF) oam_run <= 1'b0;
                end
                default: ;
            endcase
        end
    end

`ifdef Q2A03_DMC_DMA_EN
    logic       dmc_ack_q;
    logic [7:0] dmc_data_q;

    always_ff @(posedge G_clock) begin
        if (!G_reset) begin
            dmc_ack_q  <= 1'b0;
            dmc_data_q <= 8'h00;
        end else begin
            dmc_ack_q <= G_cycle && (state == DMC_GET);
            if (G_cycle && (state == DMC_GET)) dmc_data_q <= bus.bus_rd_data;
        end
    end

    assign dmc_pend     = bus.dmc_req;
    assign bus.dmc_ack  = dmc_ack_q;
    assign bus.dmc_data = dmc_data_q;
`else
    assign dmc_pend     = 1'b0;
    assign bus.dmc_ack  = 1'b0;
    assign bus.dmc_data = 8'h00;
`endif

    assign bus.bus_addr    = addr_c;
    assign bus.bus_wr_data = wr_data_c;
    assign bus.bus_rdwr    = rdwr_c;
    assign bus.cpu_ready   = cpu_ready_q;
    assign bus.dma_active  = dma_active_q;
endmodule

// File: tb/tb_q2a03_dma_arbiter.sv
// Directed bench for q2a03_dma_arbiter. Each CPU cycle is three clocks with
// the G_cycle strobe in the last one; bus outputs are sampled on the falling
// edge just before the strobe edge. Memory returns mem_f(addr).
module tb_q2a03_dma_arbiter;
    logic G_clock = 1'b0;
    logic G_reset = 1'b0;
    logic G_cycle = 1'b0;

    q2a03_dma_arbiter_if bif ();

    q2a03_dma_arbiter dut (
        .G_clock (G_clock),
        .G_reset (G_reset),
        .G_cycle (G_cycle),
        .bus     (bif)
    );

    always #5 G_clock = ~G_clock;

    function automatic logic [7:0] mem_f(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h3C;
    endfunction

    assign bif.bus_rd_data = mem_f(bif.bus_addr);

    int checks = 0;
    int failures = 0;
    int n_cyc = 0;
    int stall, acks, dmc_reads;
    logic [7:0]  ack_data;
    logic [7:0]  wq[$];
    logic [15:0] rq[$];
    logic [15:0] owa[$];
    logic [7:0]  owd[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        stall = 0; acks = 0; dmc_reads = 0; ack_data = 8'h00;
        wq.delete(); rq.delete(); owa.delete(); owd.delete();
    endtask

    task automatic cyc(input logic [15:0] a, input logic [7:0] d, input logic r);
        @(negedge G_clock);
        bif.cpu_addr = a; bif.cpu_wr_data = d; bif.cpu_rdwr = r;
        @(negedge G_clock);
        if (!bif.cpu_ready) stall++;
        if (!bif.bus_rdwr && bif.bus_addr == 16'h2004) wq.push_back(bif.bus_wr_data);
        else if (!bif.bus_rdwr && !bif.cpu_ready) begin
            owa.push_back(bif.bus_addr); owd.push_back(bif.bus_wr_data);
        end
        if (bif.bus_rdwr && bif.bus_addr == 16'hC123) dmc_reads++;
        else if (bif.bus_rdwr && bif.bus_addr != a) rq.push_back(bif.bus_addr);
        G_cycle = 1'b1;
        @(negedge G_clock);
        G_cycle = 1'b0;
        n_cyc++;
        if (bif.dmc_ack) begin
            acks++; ack_data = bif.dmc_data; bif.dmc_req = 1'b0;
        end
    endtask

    task automatic align_phase(input int want);
        if ((n_cyc % 2) != want) cyc(16'h8123, 8'h00, 1'b1);
    endtask

    task automatic run_until_idle(input string tag);
        for (int k = 0; k < 700 && bif.dma_active; k++) cyc(16'h8123, 8'h00, 1'b1);
        chk({tag, "_done_idle"}, bif.dma_active, 1'b0);
    endtask

    task automatic check_oam(input string tag, input logic [7:0] page, input int exp_stall);
        int bad;
        bad = 0;
        chk({tag, "_stall_cycles"}, stall, exp_stall);
        chk({tag, "_n_writes"}, wq.size(), 256);
        chk({tag, "_n_reads"}, rq.size(), 256);
        for (int i = 0; i < wq.size() && i < 256; i++)
            if (wq[i] !== mem_f({page, 8'(i)})) bad++;
        for (int i = 0; i < rq.size() && i < 256; i++)
            if (rq[i] !== {page, 8'(i)}) bad++;
        chk({tag, "_seq_errors"}, bad, 0);
        chk({tag, "_first_read"}, (rq.size() > 0) ? rq[0] : 16'hxxxx, {page, 8'h00});
        chk({tag, "_ready_after"}, bif.cpu_ready, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset values and mirroring
        bif.cpu_addr = 16'h1234; bif.cpu_wr_data = 8'h55; bif.cpu_rdwr = 1'b1;
        bif.dmc_req = 1'b0; bif.dmc_addr = 16'h0000;
        repeat (3) @(negedge G_clock);
        G_reset = 1'b1;
        @(negedge G_clock);
        chk("rst_cpu_ready", bif.cpu_ready, 1'b1);
        chk("rst_dma_active", bif.dma_active, 1'b0);
        chk("rst_dmc_ack", bif.dmc_ack, 1'b0);
        chk("rst_dmc_data", bif.dmc_data, 8'h00);
        chk("rst_bus_addr", bif.bus_addr, 16'h1234);
        chk("rst_bus_wr_data", bif.bus_wr_data, 8'h55);
        chk("rst_bus_rdwr", bif.bus_rdwr, 1'b1);
        bif.cpu_rdwr = 1'b0; bif.cpu_addr = 16'h0300;
        #1;
        chk("idle_mirror_write", {bif.bus_rdwr, bif.bus_addr}, {1'b0, 16'h0300});

        // page 02, trigger on phase 0
        clear_logs();
        align_phase(0);
        cyc(16'h4014, 8'h02, 1'b0);
        chk("p0_ready_fall", bif.cpu_ready, 1'b0);
        chk("p0_active", bif.dma_active, 1'b1);
        run_until_idle("p0");
        check_oam("p0", 8'h02, 513);
        chk("p0_ack_none", acks, 0);

        // page 05, trigger on phase 1 -> one ALIGN
        clear_logs();
        align_phase(1);
        cyc(16'h4014, 8'h05, 1'b0);
        run_until_idle("p1");
        check_oam("p1", 8'h05, 514);

        // two core writes after trigger stay in HALT and pass through
        clear_logs();
        align_phase(0);
        cyc(16'h4014, 8'h06, 1'b0);
        cyc(16'h01FD, 8'hAB, 1'b0);
        cyc(16'h01FC, 8'hCD, 1'b0);
        run_until_idle("wr");
        check_oam("wr", 8'h06, 515);
        chk("wr_n_passed", owa.size(), 2);
        chk("wr_pass0", (owa.size() > 0) ? {owa[0], owd[0]} : 24'h0, {16'h01FD, 8'hAB});
        chk("wr_pass1", (owa.size() > 1) ? {owa[1], owd[1]} : 24'h0, {16'h01FC, 8'hCD});

        // page FF, idx wraps back to 0 on the last put
        clear_logs();
        align_phase(0);
        cyc(16'h4014, 8'hFF, 1'b0);
        run_until_idle("pff");
        check_oam("pff", 8'hFF, 513);
        chk("pff_last_read", (rq.size() > 255) ? rq[255] : 16'h0, 16'hFFFF);

        // reset during PUT idx 40
        clear_logs();
        align_phase(0);
        cyc(16'h4014, 8'h03, 1'b0);
        for (int k = 0; k < 300 && wq.size() < 64; k++) cyc(16'h8123, 8'h00, 1'b1);
        chk("rs_reached_64", wq.size(), 64);
        cyc(16'h8123, 8'h00, 1'b1);
        @(negedge G_clock);
        chk("rs_in_put", {bif.bus_rdwr, bif.bus_addr, bif.bus_wr_data},
            {1'b0, 16'h2004, mem_f(16'h0340)});
        G_reset = 1'b0;
        @(negedge G_clock);
        G_reset = 1'b1;
        n_cyc = 0;
        chk("rs_ready", bif.cpu_ready, 1'b1);
        chk("rs_active", bif.dma_active, 1'b0);
        chk("rs_mirror", {bif.bus_rdwr, bif.bus_addr}, {1'b1, 16'h8123});
        for (int k = 0; k < 8; k++) cyc(16'h8123, 8'h00, 1'b1);
        chk("rs_no_more_writes", wq.size(), 64);
        chk("rs_still_idle", bif.dma_active, 1'b0);

        // DMC request in the middle of OAM DMA
        clear_logs();
        align_phase(0);
        cyc(16'h4014, 8'h04, 1'b0);
        for (int k = 0; k < 100 && wq.size() < 10; k++) cyc(16'h8123, 8'h00, 1'b1);
        bif.dmc_addr = 16'hC123;
        bif.dmc_req  = 1'b1;
        run_until_idle("dmc");
        bif.dmc_req = 1'b0;
`ifdef Q2A03_DMC_DMA_EN
        check_oam("dmc", 8'h04, 515);
        chk("dmc_acks", acks, 1);
        chk("dmc_reads", dmc_reads, 1);
        chk("dmc_ack_data", ack_data, mem_f(16'hC123));
        chk("dmc_data_held", bif.dmc_data, mem_f(16'hC123));
`else
        check_oam("dmc", 8'h04, 513);
        chk("dmc_acks", acks, 0);
        chk("dmc_reads", dmc_reads, 0);
        chk("dmc_data_zero", bif.dmc_data, 8'h00);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/q2a03_dma_arbiter.md
# q2a03_dma_arbiter

Bus arbiter and DMA sequencer between the Q2A03 CPU core and the system bus. It passes CPU cycles through, detects a CPU write to $4014, stalls the core through its ready input, and performs 256 OAM read/write transfers to $2004 on the shared bus. When configured in, it also arbitrates single-byte DMC sample fetches. All sequencing advances on CPU-cycle boundaries.

## Interface
Parameters:
- OAM_REG, 16'h4014: CPU write address that triggers OAM DMA.
- OAM_DATA, 16'h2004: destination address for every put cycle.

Ports:
- G_clock  in  1  system clock; one clock for the whole block.
- G_reset  in  1  reset; synchronous, active-low.
- G_cycle  in  1  one-clock strobe marking the end of a CPU cycle (divided-clock falling edge).
- cpu_addr  in  16  core address.
- cpu_wr_data  in  8  core write data.
- cpu_rdwr  in  1  core direction; 1 = read, 0 = write.
- cpu_ready  out  1  ready to the core; 0 stalls it on its next read cycle.
- bus_addr  out  16  system bus address.
- bus_wr_data  out  8  system bus write data.
- bus_rdwr  out  1  system bus direction; 1 = read.
- bus_rd_data  in  8  system bus read data.
- dma_active  out  1  1 while any state other than IDLE is active.
- dmc_req  in  1  level request for one DMC sample byte.
- dmc_addr  in  16  DMC fetch address, stable while dmc_req = 1.
- dmc_ack  out  1  one-clock pulse when the DMC fetch completes.
- dmc_data  out  8  fetched byte; valid when dmc_ack = 1 and held until the next fetch.

## Operation
- State register: IDLE, HALT, ALIGN, GET, PUT, DMC_GET. State changes only on a G_cycle strobe.
- Phase bit: 0 = get cycle, 1 = put cycle. Toggles on every strobe, including in IDLE.
- IDLE:
  - Bus mirrors cpu_addr, cpu_wr_data and cpu_rdwr. cpu_ready = 1.
  - A strobe with cpu_rdwr = 0 and cpu_addr = OAM_REG latches page = cpu_wr_data, clears idx to 0 and moves to HALT.
- HALT:
  - Bus mirrors the core, so core write cycles complete normally. cpu_ready = 0.
  - At a strobe with cpu_rdwr = 1 (the core is now stalled), go to GET if the next phase is 0, otherwise ALIGN.
  - At a strobe with cpu_rdwr = 0, stay in HALT.
- ALIGN: bus mirrors the core's held read address with bus_rdwr = 1. Go to GET at the next strobe.
- GET: bus_addr = {page, idx}, bus_rdwr = 1. At the strobe, latch bus_rd_data into the buffer and go to PUT.
- PUT: bus_addr = OAM_DATA, bus_rdwr = 0, bus_wr_data = buffer. At the strobe, idx increments modulo 256. If idx was 255, go to IDLE; otherwise go to GET.
- Transfer length: 1 halt cycle, plus 0 or 1 align cycle, plus 512 transfer cycles = 513 or 514 CPU cycles.
- cpu_ready returns to 1 in the clock after the strobe that enters IDLE.
- Outside GET, PUT and DMC_GET, bus_wr_data mirrors cpu_wr_data.
- Reset:
  - Reset mid-transfer aborts immediately. The state returns to IDLE.
  - Reset values: cpu_ready = 1, dma_active = 0, dmc_ack = 0, dmc_data = 8'h00, phase = 0, idx = 0, page = 0, buffer = 0.
  - After reset, bus outputs mirror the core.

## Timing
- cpu_ready, dma_active, dmc_ack and state are registered. cpu_ready falls one clock after the trigger strobe.
- Bus outputs are combinational from state, counters and cpu_* inputs, with no clock latency.
- First GET starts one or two CPU cycles after the trigger cycle, provided the core's next cycle is a read.
- Last PUT ends exactly 512 cycles after the first GET.

## Configuration
- Q2A03_DMC_DMA_EN defined:
  - dmc_req is sampled at strobes.
  - From IDLE: enter HALT, then ALIGN if needed, then one DMC_GET, then IDLE.
  - During OAM DMA: a request pending at a strobe that would enter GET enters DMC_GET instead, and the OAM GET is retried at the next get phase. This costs 2 extra cycles.
  - DMC_GET: bus_addr = dmc_addr, bus_rdwr = 1. At its strobe, latch dmc_data and pulse dmc_ack for 1 clock.
  - DMC takes priority over OAM on every get slot.
- Undefined: dmc_req and dmc_addr are ignored. dmc_ack = 0 and dmc_data = 8'h00 constantly. DMC_GET is unreachable.

## Test plan
- CPU writes 8'h02 to $4014 on a phase-0 cycle, then reads -> 513 cycles total; first bus read is $0200, then $2004 writes; 256 writes of mem[$0200+i]; cpu_ready low throughout.
- Same trigger on a phase-1 alignment -> one ALIGN cycle; 514 cycles total.
- Core issues two writes after the trigger (for example, JSR-style pushes) -> stays in HALT through both writes; bus passes both writes unchanged.
- Page 8'hFF -> reads $FF00..$FFFF; idx wraps to 0; return to IDLE with dma_active = 0.
- Assert G_reset = 0 for one clock at PUT idx = 8'h40 -> next clock IDLE, cpu_ready = 1, bus mirrors core, no further $2004 writes.
- With Q2A03_DMC_DMA_EN, assert dmc_req with dmc_addr = $C123 during OAM DMA -> one read of $C123, dmc_ack pulse with the byte, OAM completes in 515 or 516 cycles; without the macro, dmc_ack never asserts.
